// File: rtl/lc4_pkg.sv
// Shared LC4 writeback definitions: register-select width, default data width, W-slot records.
// No logic; types only.
// No flow control; types only.
package lc4_pkg;

    localparam int REG_SEL_W = 3;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic                 valid;
        logic [REG_SEL_W-1:0] rd;
        logic                 we;
    } w_ctrl_t;

    typedef struct packed {
        w_ctrl_t             ctrl;
        logic [DATA_W-1:0]   data;
    } w_slot_t;

endpackage

// File: rtl/lc4_wb_slot.sv
// One pipe's W register; loads M results, or a bubble on flush/hold.
// Latency: 1 cycle from M inputs to slot outputs.
// Stalls only through gwe; no backpressure of its own.
module lc4_wb_slot
    import lc4_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 bubble,
    input  logic                 m_valid,
    input  logic [REG_SEL_W-1:0] m_rd,
    input  logic                 m_we,
    input  logic [N-1:0]         m_result,
    output w_ctrl_t              w_ctrl,
    output logic [N-1:0]         w_data
);

    // On a bubble only valid drops; rd/we/data keep their old values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ctrl <= '0;
            w_data <= '0;
        end else if (gwe) begin
            if (bubble) begin
                w_ctrl.valid <= 1'b0;
            end else begin
                w_ctrl <= '{valid: m_valid, rd: m_rd, we: m_we};
                w_data <= m_result;
            end
        end
    end

endmodule

// File: rtl/lc4_wb_stage_ss.sv
// Dual-pipe LC4 writeback stage; drives regfile write ports, B wins same-rd collisions.
// Latency: 1 cycle M -> regfile write port.
// Advances only when gwe=1; flush/hold insert bubbles, no upstream backpressure.
module lc4_wb_stage_ss
    import lc4_pkg::*;
#(
    parameter int n     = DATA_W,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 i_flush,
    input  logic                 i_m_hold,
    input  logic                 i_m_valid_A,
    input  logic                 i_m_valid_B,
    input  logic [REG_SEL_W-1:0] i_m_rd_A,
    input  logic [REG_SEL_W-1:0] i_m_rd_B,
    input  logic                 i_m_rd_we_A,
    input  logic                 i_m_rd_we_B,
    input  logic [n-1:0]         i_m_result_A,
    input  logic [n-1:0]         i_m_result_B,
    output logic [REG_SEL_W-1:0] o_rd_A,
    output logic [REG_SEL_W-1:0] o_rd_B,
    output logic [n-1:0]         o_wdata_A,
    output logic [n-1:0]         o_wdata_B,
    output logic                 o_rd_we_A,
    output logic                 o_rd_we_B,
    output logic                 o_w_valid_A,
    output logic                 o_w_valid_B,
    output logic [CNT_W-1:0]     o_retired,
    output logic [CNT_W-1:0]     o_collisions,
    output logic                 o_order_err
);

    localparam int SUM_W = CNT_W + 1;

    w_ctrl_t        ctrl_A, ctrl_B;
    logic [n-1:0]   data_A, data_B;
    logic           bubble;
    logic           a_clash;
    logic           a_suppressed;
    logic           order_viol;
    logic [CNT_W:0] ret_sum;

    assign bubble = i_flush | i_m_hold;

    lc4_wb_slot #(.N(n)) u_slot_A (
        .clk      (clk),
        .rst      (rst),
        .gwe      (gwe),
        .bubble   (bubble),
        .m_valid  (i_m_valid_A),
        .m_rd     (i_m_rd_A),
        .m_we     (i_m_rd_we_A),
        .m_result (i_m_result_A),
        .w_ctrl   (ctrl_A),
        .w_data   (data_A)
    );

    lc4_wb_slot #(.N(n)) u_slot_B (
        .clk      (clk),
        .rst      (rst),
        .gwe      (gwe),
        .bubble   (bubble),
        .m_valid  (i_m_valid_B),
        .m_rd     (i_m_rd_B),
        .m_we     (i_m_rd_we_B),
        .m_result (i_m_result_B),
        .w_ctrl   (ctrl_B),
        .w_data   (data_B)
    );

    // B is younger, so its value is the architecturally final one for a shared rd.
    assign o_rd_we_B    = ctrl_B.valid & ctrl_B.we;
    assign a_clash      = o_rd_we_B & (ctrl_A.rd == ctrl_B.rd);
    assign a_suppressed = ctrl_A.valid & ctrl_A.we & a_clash;
    assign o_rd_we_A    = ctrl_A.valid & ctrl_A.we & ~a_clash;

    assign o_rd_A      = ctrl_A.rd;
    assign o_rd_B      = ctrl_B.rd;
    assign o_wdata_A   = data_A;
    assign o_wdata_B   = data_B;
    assign o_w_valid_A = ctrl_A.valid;
    assign o_w_valid_B = ctrl_B.valid;

    assign ret_sum    = {1'b0, o_retired} + SUM_W'(ctrl_A.valid) + SUM_W'(ctrl_B.valid);
    assign order_viol = ~bubble & i_m_valid_B & ~i_m_valid_A;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_retired    <= '0;
            o_collisions <= '0;
            o_order_err  <= 1'b0;
        end else if (gwe) begin
            o_retired <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
            if (a_suppressed && (o_collisions != '1))
                o_collisions <= o_collisions + CNT_W'(1);
            if (order_viol)
                o_order_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lc4_wb_stage_ss.sv
// Directed bench for lc4_wb_stage_ss with a transaction-level model and literal spot checks.
module tb_lc4_wb_stage_ss;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gwe = 1'b1;
    logic        flush = 1'b0, hold = 1'b0;
    logic        va = 1'b0, vb = 1'b0, wa = 1'b0, wb = 1'b0;
    logic [2:0]  ra = '0, rb = '0;
    logic [15:0] da = '0, db = '0;

    logic [2:0]       o_rd_A, o_rd_B;
    logic [15:0]      o_wdata_A, o_wdata_B;
    logic             o_rd_we_A, o_rd_we_B, o_w_valid_A, o_w_valid_B, o_order_err;
    logic [CNT_W-1:0] o_retired, o_collisions;

    int pass_cnt = 0;
    int total_cnt = 0;

    lc4_wb_stage_ss #(.n(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .gwe(gwe), .i_flush(flush), .i_m_hold(hold),
        .i_m_valid_A(va), .i_m_valid_B(vb), .i_m_rd_A(ra), .i_m_rd_B(rb),
        .i_m_rd_we_A(wa), .i_m_rd_we_B(wb), .i_m_result_A(da), .i_m_result_B(db),
        .o_rd_A(o_rd_A), .o_rd_B(o_rd_B), .o_wdata_A(o_wdata_A), .o_wdata_B(o_wdata_B),
        .o_rd_we_A(o_rd_we_A), .o_rd_we_B(o_rd_we_B),
        .o_w_valid_A(o_w_valid_A), .o_w_valid_B(o_w_valid_B),
        .o_retired(o_retired), .o_collisions(o_collisions), .o_order_err(o_order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: what W holds is simply what M presented at the last enabled, non-bubble edge.
    logic        mv_A = 0, mv_B = 0, mwe_A = 0, mwe_B = 0, m_err = 0;
    logic [2:0]  mrd_A = 0, mrd_B = 0;
    logic [15:0] mdat_A = 0, mdat_B = 0;
    int          m_ret = 0, m_col = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mv_A = 0; mv_B = 0; mwe_A = 0; mwe_B = 0; m_err = 0;
            mrd_A = 0; mrd_B = 0; mdat_A = 0; mdat_B = 0;
            m_ret = 0; m_col = 0;
        end else if (gwe) begin
            m_ret = m_ret + int'(mv_A) + int'(mv_B);
            if (m_ret > CMAX) m_ret = CMAX;
            if (mv_A && mwe_A && mv_B && mwe_B && mrd_A == mrd_B && m_col < CMAX) m_col++;
            if (!flush && !hold && vb && !va) m_err = 1;
            if (flush || hold) begin
                mv_A = 0; mv_B = 0;
            end else begin
                mv_A = va; mrd_A = ra; mwe_A = wa; mdat_A = da;
                mv_B = vb; mrd_B = rb; mwe_B = wb; mdat_B = db;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_we_A, exp_we_B;
        exp_we_B = mv_B && mwe_B;
        exp_we_A = mv_A && mwe_A && !(exp_we_B && mrd_A == mrd_B);
        check("cmp_w_valid_A", 32'(o_w_valid_A), 32'(mv_A));
        check("cmp_w_valid_B", 32'(o_w_valid_B), 32'(mv_B));
        check("cmp_rd_we_A", 32'(o_rd_we_A), 32'(exp_we_A));
        check("cmp_rd_we_B", 32'(o_rd_we_B), 32'(exp_we_B));
        check("cmp_retired", 32'(o_retired), 32'(m_ret));
        check("cmp_collisions", 32'(o_collisions), 32'(m_col));
        check("cmp_order_err", 32'(o_order_err), 32'(m_err));
        if (mv_A) begin
            check("cmp_rd_A", 32'(o_rd_A), 32'(mrd_A));
            check("cmp_wdata_A", 32'(o_wdata_A), 32'(mdat_A));
        end
        if (mv_B) begin
            check("cmp_rd_B", 32'(o_rd_B), 32'(mrd_B));
            check("cmp_wdata_B", 32'(o_wdata_B), 32'(mdat_B));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input logic v_a, input logic [2:0] r_a, input logic w_a, input logic [15:0] d_a,
                         input logic v_b, input logic [2:0] r_b, input logic w_b, input logic [15:0] d_b);
        va = v_a; ra = r_a; wa = w_a; da = d_a;
        vb = v_b; rb = r_b; wb = w_b; db = d_b;
    endtask

    task automatic idle();
        set_m(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        check("rst_w_valid_A", 32'(o_w_valid_A), 0);
        check("rst_rd_we_B", 32'(o_rd_we_B), 0);
        check("rst_wdata_B", 32'(o_wdata_B), 0);
        check("rst_retired", 32'(o_retired), 0);
        repeat (5) cyc();
        check("idle_retired", 32'(o_retired), 0);

        // Dual write
        set_m(1, 3'd3, 1, 16'h1234, 1, 3'd5, 1, 16'hBEEF);
        cyc();
        idle();
        check("dual_we_A", 32'(o_rd_we_A), 1);
        check("dual_rd_A", 32'(o_rd_A), 3);
        check("dual_wdata_A", 32'(o_wdata_A), 32'h1234);
        check("dual_we_B", 32'(o_rd_we_B), 1);
        check("dual_rd_B", 32'(o_rd_B), 5);
        check("dual_wdata_B", 32'(o_wdata_B), 32'hBEEF);
        cyc();
        check("dual_retired", 32'(o_retired), 2);

        // Collision
        set_m(1, 3'd2, 1, 16'h1111, 1, 3'd2, 1, 16'h2222);
        cyc();
        idle();
        check("coll_we_A", 32'(o_rd_we_A), 0);
        check("coll_we_B", 32'(o_rd_we_B), 1);
        check("coll_wdata_B", 32'(o_wdata_B), 32'h2222);
        cyc();
        check("coll_count", 32'(o_collisions), 1);
        check("coll_retired", 32'(o_retired), 4);

        // Flush, hold, and both together
        for (int k = 0; k < 3; k++) begin
            set_m(1, 3'd1, 1, 16'h0A0A, 1, 3'd4, 1, 16'h0B0B);
            flush = (k != 1);
            hold  = (k != 0);
            cyc();
            flush = 1'b0; hold = 1'b0;
            idle();
            check("bubble_we_A", 32'(o_rd_we_A), 0);
            check("bubble_we_B", 32'(o_rd_we_B), 0);
            check("bubble_retired", 32'(o_retired), 4);
        end

        // gwe freeze
        set_m(1, 3'd6, 1, 16'hAAAA, 1, 3'd7, 1, 16'h5555);
        cyc();
        gwe = 1'b0;
        set_m(1, 3'd0, 1, 16'hDEAD, 1, 3'd1, 1, 16'hBEAD);
        repeat (3) cyc();
        check("frz_rd_A", 32'(o_rd_A), 6);
        check("frz_wdata_A", 32'(o_wdata_A), 32'hAAAA);
        check("frz_we_B", 32'(o_rd_we_B), 1);
        check("frz_retired", 32'(o_retired), 4);
        gwe = 1'b1;
        idle();
        cyc();
        check("unfrz_retired", 32'(o_retired), 6);

        // Order error, then legal traffic up to saturation
        set_m(0, 3'd0, 0, 16'h0, 1, 3'd0, 1, 16'h0F0F);
        cyc();
        check("ord_err", 32'(o_order_err), 1);
        check("ord_w_valid_B", 32'(o_w_valid_B), 1);
        check("ord_wdata_B", 32'(o_wdata_B), 32'h0F0F);
        set_m(1, 3'd1, 1, 16'h0001, 0, 3'd0, 0, 16'h0);
        cyc();
        check("ord_retired", 32'(o_retired), 7);
        set_m(1, 3'd1, 1, 16'h0011, 1, 3'd2, 1, 16'h0022);
        repeat (4) cyc();
        check("sat_retired_14", 32'(o_retired), 14);
        check("ord_err_sticky", 32'(o_order_err), 1);
        cyc();
        check("sat_retired_15", 32'(o_retired), 15);
        cyc();
        check("sat_retired_hold", 32'(o_retired), 15);

        // Asynchronous reset mid-cycle
        #1 rst = 1'b0;
        #1;
        check("arst_retired", 32'(o_retired), 0);
        check("arst_order_err", 32'(o_order_err), 0);
        check("arst_we_A", 32'(o_rd_we_A), 0);
        check("arst_wdata_B", 32'(o_wdata_B), 0);
        check("arst_rd_B", 32'(o_rd_B), 0);
        idle();
        cyc();
        rst = 1'b1;
        repeat (2) cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
